// File: rtl/ram_sdp_init.sv
// Simple-dual-port RAM with byte-masked writes, write-first forwarding,
// hardware initialisation (after reset or on clear) and optional output register.
module ram_sdp_init #(
    parameter int unsigned         D_WIDTH    = 16,
    parameter int unsigned         A_WIDTH    = 4,
    parameter int unsigned         A_MAX      = 16,
    parameter int unsigned         OUT_REG    = 0,
    parameter logic [D_WIDTH-1:0]  INIT_VALUE = '0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clear,
    output logic                   busy,
    input  logic                   write_enable,
    input  logic [A_WIDTH-1:0]     address_write,
    input  logic [D_WIDTH-1:0]     data_write,
    input  logic [D_WIDTH/8-1:0]   byte_enable,
    input  logic                   read_enable,
    input  logic [A_WIDTH-1:0]     address_read,
    output logic [D_WIDTH-1:0]     data_read,
    output logic                   read_valid
);
    localparam int unsigned        NB        = D_WIDTH / 8;
    localparam int unsigned        NSTG      = (OUT_REG != 0) ? 2 : 1;
    localparam logic [A_WIDTH-1:0] LAST_ADDR = A_WIDTH'(A_MAX - 1);

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t               state, state_nx;
    logic [A_WIDTH-1:0]   cnt, cnt_nx;
    logic                 busy_nx;
    logic                 wr_in, rd_in, wr_go, rd_go;
    logic [D_WIDTH-1:0]   mem [A_MAX];
    logic [D_WIDTH-1:0]   rd_word;
    logic [NSTG:0]        vld;
    logic [D_WIDTH-1:0]   dat [NSTG+1];

    // Control state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_INIT;
            cnt   <= '0;
            busy  <= 1'b1;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            busy  <= busy_nx;
        end
    end

    // Next state: clear restarts the init sweep from address 0 in any state
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        if (clear) begin
            state_nx = ST_INIT;
            cnt_nx   = '0;
        end else if (state == ST_INIT) begin
            if (cnt == LAST_ADDR) begin
                state_nx = ST_RUN;
                cnt_nx   = '0;
            end else begin
                cnt_nx = cnt + A_WIDTH'(1);
            end
        end
        busy_nx = (state_nx == ST_INIT);
    end

    assign wr_in = 32'(address_write) < A_MAX;
    assign rd_in = 32'(address_read) < A_MAX;
    assign wr_go = (state == ST_RUN) && !clear && write_enable && wr_in;
    assign rd_go = (state == ST_RUN) && !clear && read_enable;

    // Read word with write-first merge; out-of-range reads return zero
    always_comb begin
        rd_word = '0;
        if (rd_in) begin
            rd_word = mem[address_read];
            if (write_enable && (address_write == address_read)) begin
                for (int i = 0; i < NB; i++) begin
                    if (byte_enable[i]) rd_word[8*i +: 8] = data_write[8*i +: 8];
                end
            end
        end
    end

    // Storage array is never reset; the init sweep overwrites it instead
    always_ff @(posedge clk) begin
        if (state == ST_INIT) begin
            mem[cnt] <= INIT_VALUE;
        end else if (wr_go) begin
            for (int i = 0; i < NB; i++) begin
                if (byte_enable[i]) mem[address_write][8*i +: 8] <= data_write[8*i +: 8];
            end
        end
    end

    // Read pipeline: stage 0 samples at the accepting edge, data moves only with valid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld <= '0;
            for (int i = 0; i <= NSTG; i++) dat[i] <= '0;
        end else begin
            vld <= {vld[NSTG-1:0], rd_go};
            if (rd_go) dat[0] <= rd_word;
            for (int i = 1; i <= NSTG; i++) begin
                if (vld[i-1]) dat[i] <= dat[i-1];
            end
        end
    end

    assign read_valid = vld[NSTG];
    assign data_read  = dat[NSTG];

endmodule

// File: tb/tb_ram_sdp_init.sv
// Bench for ram_sdp_init: two instances (16 words/latency 1, 12 words/latency 2)
// driven in lockstep and compared every edge against an array-based model.
module tb_ram_sdp_init;
    localparam bit Y = 1'b1;
    localparam bit N = 1'b0;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear = 1'b0;
    logic        write_enable = 1'b0;
    logic [3:0]  address_write = '0;
    logic [15:0] data_write = '0;
    logic [1:0]  byte_enable = '0;
    logic        read_enable = 1'b0;
    logic [3:0]  address_read = '0;

    logic [1:0]  busy_w;
    logic [1:0]  rv_w;
    logic [15:0] dr_w [2];

    always #5 clk = ~clk;

    ram_sdp_init #(.D_WIDTH(16), .A_WIDTH(4), .A_MAX(16), .OUT_REG(0), .INIT_VALUE(16'hA5A5)) dut_a (
        .clk(clk), .rst_n(rst_n), .clear(clear), .busy(busy_w[0]),
        .write_enable(write_enable), .address_write(address_write), .data_write(data_write),
        .byte_enable(byte_enable), .read_enable(read_enable), .address_read(address_read),
        .data_read(dr_w[0]), .read_valid(rv_w[0]));

    ram_sdp_init #(.D_WIDTH(16), .A_WIDTH(4), .A_MAX(12), .OUT_REG(1), .INIT_VALUE(16'h5A5A)) dut_b (
        .clk(clk), .rst_n(rst_n), .clear(clear), .busy(busy_w[1]),
        .write_enable(write_enable), .address_write(address_write), .data_write(data_write),
        .byte_enable(byte_enable), .read_enable(read_enable), .address_read(address_read),
        .data_read(dr_w[1]), .read_valid(rv_w[1]));

    // Reference model: word arrays, remaining-init countdown, delay line of read results
    int          amax_c [2] = '{16, 12};
    int          lat_c  [2] = '{1, 2};
    logic [15:0] initv_c[2] = '{16'hA5A5, 16'h5A5A};
    logic [15:0] mem_m [2][16];
    int          busy_left [2];
    logic        hv [2][3];
    logic [15:0] hd [2][3];
    logic [15:0] ed [2];

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        we;
        logic [3:0]  aw;
        logic [15:0] dw;
        logic [1:0]  be;
        logic        re;
        logic [3:0]  ar;
        logic        va;
        logic [15:0] da;
        logic        vb;
        logic [15:0] db;
    } vec_t;

    vec_t tbl [21];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            busy_left[k] = amax_c[k];
            ed[k] = '0;
            for (int j = 0; j < 3; j++) begin
                hv[k][j] = 1'b0;
                hd[k][j] = '0;
            end
        end
    endtask

    task automatic model_edge(input int k);
        logic        acc;
        logic [15:0] word;
        int          amax;
        amax = amax_c[k];
        acc  = (busy_left[k] == 0) && !clear && read_enable;
        word = '0;
        if (acc && int'(address_read) < amax) begin
            word = mem_m[k][address_read];
            if (write_enable && address_write == address_read) begin
                for (int b = 0; b < 2; b++)
                    if (byte_enable[b]) word[8*b +: 8] = data_write[8*b +: 8];
            end
        end
        if (busy_left[k] == 0 && !clear && write_enable && int'(address_write) < amax) begin
            for (int b = 0; b < 2; b++)
                if (byte_enable[b]) mem_m[k][address_write][8*b +: 8] = data_write[8*b +: 8];
        end
        if (clear) begin
            busy_left[k] = amax;
        end else if (busy_left[k] > 0) begin
            mem_m[k][amax - busy_left[k]] = initv_c[k];
            busy_left[k]--;
        end
        hv[k][2] = hv[k][1]; hd[k][2] = hd[k][1];
        hv[k][1] = hv[k][0]; hd[k][1] = hd[k][0];
        hv[k][0] = acc;      hd[k][0] = word;
        if (hv[k][lat_c[k]]) ed[k] = hd[k][lat_c[k]];
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            model_edge(k);
            check($sformatf("busy[%0d]", k), 32'(busy_w[k]), 32'(busy_left[k] > 0));
            check($sformatf("read_valid[%0d]", k), 32'(rv_w[k]), 32'(hv[k][lat_c[k]]));
            check($sformatf("data_read[%0d]", k), 32'(dr_w[k]), 32'(ed[k]));
        end
    endtask

    task automatic drive(input logic c, input logic we, input logic [3:0] aw, input logic [15:0] dw,
                         input logic [1:0] be, input logic re, input logic [3:0] ar);
        clear = c; write_enable = we; address_write = aw; data_write = dw;
        byte_enable = be; read_enable = re; address_read = ar;
    endtask

    task automatic idle();
        drive(N, N, 4'd0, 16'h0, 2'b00, N, 4'd0);
    endtask

    function automatic vec_t v(input logic we, input logic [3:0] aw, input logic [15:0] dw,
                               input logic [1:0] be, input logic re, input logic [3:0] ar,
                               input logic va, input logic [15:0] da, input logic vb, input logic [15:0] db);
        vec_t r;
        r.we = we; r.aw = aw; r.dw = dw; r.be = be; r.re = re; r.ar = ar;
        r.va = va; r.da = da; r.vb = vb; r.db = db;
        return r;
    endfunction

    initial begin
        int busy_cnt [2];

        // Expected columns: outputs after the row's edge (dut_a shows row-1 read, dut_b row-2 read)
        tbl[0]  = v(Y, 4'd3,  16'h1234, 2'b11, N, 4'd0,  N, 16'h0,    N, 16'h0);
        tbl[1]  = v(Y, 4'd3,  16'hABCD, 2'b10, N, 4'd0,  N, 16'h0,    N, 16'h0);
        tbl[2]  = v(N, 4'd0,  16'h0,    2'b00, Y, 4'd3,  N, 16'h0,    N, 16'h0);
        tbl[3]  = v(N, 4'd0,  16'h0,    2'b00, N, 4'd0,  Y, 16'hAB34, N, 16'h0);
        tbl[4]  = v(Y, 4'd5,  16'h0000, 2'b11, N, 4'd0,  N, 16'h0,    Y, 16'hAB34);
        tbl[5]  = v(Y, 4'd5,  16'hBEEF, 2'b01, Y, 4'd5,  N, 16'h0,    N, 16'h0);
        tbl[6]  = v(N, 4'd0,  16'h0,    2'b00, N, 4'd0,  Y, 16'h00EF, N, 16'h0);
        tbl[7]  = v(Y, 4'd0,  16'h0001, 2'b11, N, 4'd0,  N, 16'h0,    Y, 16'h00EF);
        tbl[8]  = v(Y, 4'd1,  16'h0002, 2'b11, N, 4'd0,  N, 16'h0,    N, 16'h0);
        tbl[9]  = v(Y, 4'd2,  16'h0003, 2'b11, N, 4'd0,  N, 16'h0,    N, 16'h0);
        tbl[10] = v(Y, 4'd3,  16'h0004, 2'b11, N, 4'd0,  N, 16'h0,    N, 16'h0);
        tbl[11] = v(N, 4'd0,  16'h0,    2'b00, Y, 4'd0,  N, 16'h0,    N, 16'h0);
        tbl[12] = v(N, 4'd0,  16'h0,    2'b00, Y, 4'd1,  Y, 16'h0001, N, 16'h0);
        tbl[13] = v(N, 4'd0,  16'h0,    2'b00, Y, 4'd2,  Y, 16'h0002, Y, 16'h0001);
        tbl[14] = v(N, 4'd0,  16'h0,    2'b00, Y, 4'd3,  Y, 16'h0003, Y, 16'h0002);
        tbl[15] = v(N, 4'd0,  16'h0,    2'b00, N, 4'd0,  Y, 16'h0004, Y, 16'h0003);
        tbl[16] = v(N, 4'd0,  16'h0,    2'b00, N, 4'd0,  N, 16'h0,    Y, 16'h0004);
        tbl[17] = v(Y, 4'd13, 16'hFFFF, 2'b11, N, 4'd0,  N, 16'h0,    N, 16'h0);
        tbl[18] = v(N, 4'd0,  16'h0,    2'b00, Y, 4'd13, N, 16'h0,    N, 16'h0);
        tbl[19] = v(N, 4'd0,  16'h0,    2'b00, N, 4'd0,  Y, 16'hFFFF, N, 16'h0);
        tbl[20] = v(N, 4'd0,  16'h0,    2'b00, N, 4'd0,  N, 16'h0,    Y, 16'h0000);

        for (int k = 0; k < 2; k++)
            for (int a = 0; a < 16; a++) mem_m[k][a] = '0;
        model_reset();
        idle();
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            check($sformatf("reset busy[%0d]", k), 32'(busy_w[k]), 32'd1);
            check($sformatf("reset read_valid[%0d]", k), 32'(rv_w[k]), 32'd0);
            check($sformatf("reset data_read[%0d]", k), 32'(dr_w[k]), 32'd0);
        end
        rst_n = 1'b1;

        // Initial sweep with accesses presented (must be ignored while busy)
        drive(N, Y, 4'd1, 16'h7777, 2'b11, Y, 4'd1);
        repeat (16) step();
        idle();
        for (int a = 0; a < 16; a++) begin
            drive(N, N, 4'd0, 16'h0, 2'b00, Y, 4'(a));
            step();
        end
        idle();
        repeat (3) step();

        // Directed table
        for (int i = 0; i < 21; i++) begin
            drive(N, tbl[i].we, tbl[i].aw, tbl[i].dw, tbl[i].be, tbl[i].re, tbl[i].ar);
            step();
            check($sformatf("tbl%0d valid_a", i), 32'(rv_w[0]), 32'(tbl[i].va));
            if (tbl[i].va) check($sformatf("tbl%0d data_a", i), 32'(dr_w[0]), 32'(tbl[i].da));
            check($sformatf("tbl%0d valid_b", i), 32'(rv_w[1]), 32'(tbl[i].vb));
            if (tbl[i].vb) check($sformatf("tbl%0d data_b", i), 32'(dr_w[1]), 32'(tbl[i].db));
        end
        for (int a = 0; a < 16; a++) begin
            drive(N, N, 4'd0, 16'h0, 2'b00, Y, 4'(a));
            step();
        end
        idle();
        repeat (3) step();

        // Clear with a colliding write/read, then accesses while busy
        drive(Y, Y, 4'd0, 16'h1111, 2'b11, Y, 4'd0);
        step();
        for (int k = 0; k < 2; k++) busy_cnt[k] = int'(busy_w[k]);
        drive(N, Y, 4'd2, 16'h2222, 2'b11, Y, 4'd2);
        for (int i = 0; i < 20; i++) begin
            step();
            for (int k = 0; k < 2; k++) busy_cnt[k] += int'(busy_w[k]);
        end
        check("clear busy cycles a", 32'(busy_cnt[0]), 32'd16);
        check("clear busy cycles b", 32'(busy_cnt[1]), 32'd12);
        idle();
        repeat (3) step();
        for (int a = 0; a < 16; a++) begin
            drive(N, N, 4'd0, 16'h0, 2'b00, Y, 4'(a));
            step();
        end
        idle();
        repeat (3) step();

        // Randomized traffic including occasional clears
        for (int i = 0; i < 400; i++) begin
            drive(logic'($urandom_range(0, 39) == 0), logic'($urandom_range(0, 1)),
                  4'($urandom_range(0, 15)), 16'($urandom), 2'($urandom_range(0, 3)),
                  logic'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
            step();
        end
        idle();
        repeat (20) step();

        // Reset in the middle of a read burst
        drive(N, N, 4'd0, 16'h0, 2'b00, Y, 4'd2);
        repeat (3) step();
        check("pre-reset valid a", 32'(rv_w[0]), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid-reset valid a", 32'(rv_w[0]), 32'd0);
        check("mid-reset valid b", 32'(rv_w[1]), 32'd0);
        model_reset();
        idle();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            for (int k = 0; k < 2; k++) begin
                check($sformatf("in-reset valid[%0d]", k), 32'(rv_w[k]), 32'd0);
                check($sformatf("in-reset busy[%0d]", k), 32'(busy_w[k]), 32'd1);
            end
        end
        rst_n = 1'b1;
        repeat (18) step();
        for (int a = 0; a < 16; a++) begin
            drive(N, N, 4'd0, 16'h0, 2'b00, Y, 4'(a));
            step();
        end
        idle();
        repeat (3) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ram_sdp_init.md
# ram_sdp_init

Parametrised simple-dual-port synchronous RAM: one write port with per-byte write enables and one read port with a read-enable/valid handshake. Adds hardware initialisation after reset or on demand, write-first forwarding for same-address read/write, and an optional output register stage. It is the general storage primitive for register files, lookup tables and FIFO backing stores in the design.

## Interface
- D_WIDTH, 16, data width in bits; must be a multiple of 8.
- A_WIDTH, 4, address width in bits.
- A_MAX, 16, number of words; 1 ≤ A_MAX ≤ 2^A_WIDTH.
- OUT_REG, 0, 0: read latency 1 cycle; 1: one extra output register, read latency 2 cycles.
- INIT_VALUE, 0, D_WIDTH-bit word written to every location during initialisation.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- clear  in  1  request re-initialisation of the whole memory.
- busy  out  1  high while the block is initialising; accesses are ignored.
- write_enable  in  1  write request.
- address_write  in  A_WIDTH  write address.
- data_write  in  D_WIDTH  write data.
- byte_enable  in  D_WIDTH/8  per-byte write mask; bit i covers data bits [8i+7:8i].
- read_enable  in  1  read request.
- address_read  in  A_WIDTH  read address.
- data_read  out  D_WIDTH  read data.
- read_valid  out  1  one-cycle strobe marking valid data_read.

## Operation
- State machine has two states: INIT and RUN.
- Reset (rst_n low, asynchronous):
  - state goes to INIT with the init counter at 0.
  - busy=1, read_valid=0, data_read=0, and all pipeline registers cleared.
  - Memory array contents are not reset.
- INIT: each edge writes INIT_VALUE to the address held in the init counter, then increments the counter. After writing A_MAX-1, the state moves to RUN.
- While busy=1, write_enable and read_enable are ignored; no read_valid is generated for them.
- RUN:
  - clear high at an edge moves the state to INIT with the counter at 0. Any write or read presented at that same edge is dropped, because clear has priority.
  - clear high during INIT restarts the counter at 0.
- Write, when write_enable=1 and busy=0:
  - Bytes whose byte_enable bit is set are updated from data_write.
  - Other bytes keep their old value.
  - byte_enable=0 makes the write a no-op.
- Read, when read_enable=1 and busy=0: the word is sampled at the accepting edge.
- Same-address read and write in one cycle use write-first forwarding. The read returns the merged word: enabled bytes from data_write, the remaining bytes from memory.
- Address ≥ A_MAX:
  - A write is dropped.
  - A read is accepted and returns all zeros, with read_valid asserted.
- data_read holds its last value between reads. It changes only when read_valid rises.
- Reads accepted before a clear still complete with pre-clear data and assert read_valid.

## Timing
- Edge numbering starts at the first rising edge after rst_n deasserts (edge 1). Edges 1..A_MAX write addresses 0..A_MAX-1.
- busy falls after edge A_MAX. The first access is accepted at edge A_MAX+1.
- clear at edge E:
  - busy=1 after E.
  - Init writes happen at E+1..E+A_MAX.
  - busy=0 after E+A_MAX.
- Read latency:
  - read accepted at edge N → data_read/read_valid valid after edge N+1 (OUT_REG=0) or edge N+2 (OUT_REG=1).
  - read_valid is high for exactly one cycle per accepted read.
  - Throughput is one read and one write per cycle, back-to-back, with no bubbles.
- A write at edge N is visible to a non-forwarded read accepted at edge N+1 or later.
- rst_n asserted mid-operation aborts in-flight reads: read_valid=0 immediately, with no later strobe.

## Test plan
- Reset init: D_WIDTH=16, A_MAX=16, INIT_VALUE=16'hA5A5. Release reset, then read all 16 addresses → busy is low for the first time after edge 16, and every read returns 16'hA5A5 one cycle later with read_valid.
- Byte enables: write 16'h1234 with byte_enable=2'b11 to address 3, then 16'hABCD with byte_enable=2'b10 → a read of address 3 returns 16'hAB34.
- Forwarding: memory[5]=16'h0000; in the same cycle write 16'hBEEF with byte_enable=2'b01 and read address 5 → data_read=16'h00EF after the next edge.
- Latency: OUT_REG=1, four back-to-back reads of addresses 0..3 holding 1,2,3,4 → read_valid high for 4 consecutive cycles starting 2 cycles after the first accept, with data 1,2,3,4 in order.
- Clear: a write and a read are presented with clear high → both are dropped, busy stays high for 16 cycles, and every location then reads INIT_VALUE. An access presented while busy produces no read_valid.
- Edge cases: A_MAX=12 with A_WIDTH=4. Write 16'hFFFF to address 13, then read address 13 → returns 0 with read_valid, and addresses 0..11 are unchanged. Assert rst_n mid-read → read_valid is low immediately and no strobe follows.
